// File: rtl/one_to_n_router.sv
// one_to_n_router: per-lane address-window request routing to N targets, plus
// per-target response FIFOs merged back to the pipeline by a locking
// round-robin arbiter.
module one_to_n_router #(
    parameter int NUM_REQS    = 4,
    parameter int NUM_TARGETS = 3,
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 8,
    parameter int RSP_DEPTH   = 2,
    // Window t is [TGT_BASE[t], TGT_END[t]); default leaves the last target
    // with an empty window so it only catches unmatched addresses.
    parameter logic [NUM_TARGETS-1:0][ADDR_W-1:0] TGT_BASE = {30'h0, 30'h100, 30'h0},
    parameter logic [NUM_TARGETS-1:0][ADDR_W-1:0] TGT_END  = {30'h0, 30'h200, 30'h100},
    parameter int DEFAULT_TGT = NUM_TARGETS - 1
) (
    input  logic                                               clk_i,
    input  logic                                               rst_i,
    // pipeline request side
    input  logic [NUM_REQS-1:0]                                pipe_req_valid,
    input  logic [NUM_REQS-1:0]                                pipe_req_rw,
    input  logic [NUM_REQS-1:0][3:0]                           pipe_req_byteen,
    input  logic [NUM_REQS-1:0][ADDR_W-1:0]                    pipe_req_addr,
    input  logic [NUM_REQS-1:0][DATA_W-1:0]                    pipe_req_data,
    input  logic [NUM_REQS-1:0][TAG_W-1:0]                     pipe_req_tag,
    output logic [NUM_REQS-1:0]                                pipe_req_ready,
    // per-target request ports
    output logic [NUM_TARGETS-1:0][NUM_REQS-1:0]               tgt_req_valid,
    output logic [NUM_TARGETS-1:0][NUM_REQS-1:0]               tgt_req_rw,
    output logic [NUM_TARGETS-1:0][NUM_REQS-1:0][3:0]          tgt_req_byteen,
    output logic [NUM_TARGETS-1:0][NUM_REQS-1:0][ADDR_W-1:0]   tgt_req_addr,
    output logic [NUM_TARGETS-1:0][NUM_REQS-1:0][DATA_W-1:0]   tgt_req_data,
    output logic [NUM_TARGETS-1:0][NUM_REQS-1:0][TAG_W-1:0]    tgt_req_tag,
    input  logic [NUM_TARGETS-1:0][NUM_REQS-1:0]               tgt_req_ready,
    // per-target response ports
    input  logic [NUM_TARGETS-1:0]                             tgt_rsp_valid,
    input  logic [NUM_TARGETS-1:0][TAG_W-1:0]                  tgt_rsp_tag,
    input  logic [NUM_TARGETS-1:0][NUM_REQS-1:0]               tgt_rsp_tmask,
    input  logic [NUM_TARGETS-1:0][NUM_REQS-1:0][DATA_W-1:0]   tgt_rsp_data,
    output logic [NUM_TARGETS-1:0]                             tgt_rsp_ready,
    // merged response to the pipeline
    output logic                                               pipe_rsp_valid,
    output logic [TAG_W-1:0]                                   pipe_rsp_tag,
    output logic [NUM_REQS-1:0]                                pipe_rsp_tmask,
    output logic [NUM_REQS-1:0][DATA_W-1:0]                    pipe_rsp_data,
    input  logic                                               pipe_rsp_ready
);

    localparam int TW = $clog2(NUM_TARGETS);
    localparam int PW = $clog2(RSP_DEPTH);

    logic [NUM_REQS-1:0][TW-1:0] lane_sel;

    // Per-lane target decode: lowest matching window wins, else the default.
    always_comb begin
        for (int l = 0; l < NUM_REQS; l++) begin
            lane_sel[l] = TW'(DEFAULT_TGT);
            for (int t = NUM_TARGETS - 1; t >= 0; t--) begin
                if (pipe_req_addr[l] >= TGT_BASE[t] && pipe_req_addr[l] < TGT_END[t])
                    lane_sel[l] = TW'(t);
            end
        end
    end

    // Steer each lane to its target only; everything else sees zeros.
    always_comb begin
        tgt_req_valid  = '0;
        tgt_req_rw     = '0;
        tgt_req_byteen = '0;
        tgt_req_addr   = '0;
        tgt_req_data   = '0;
        tgt_req_tag    = '0;
        pipe_req_ready = '0;
        for (int l = 0; l < NUM_REQS; l++) begin
            tgt_req_valid[lane_sel[l]][l]  = pipe_req_valid[l];
            tgt_req_rw[lane_sel[l]][l]     = pipe_req_rw[l];
            tgt_req_byteen[lane_sel[l]][l] = pipe_req_byteen[l];
            tgt_req_addr[lane_sel[l]][l]   = pipe_req_addr[l];
            tgt_req_data[lane_sel[l]][l]   = pipe_req_data[l];
            tgt_req_tag[lane_sel[l]][l]    = pipe_req_tag[l];
            pipe_req_ready[l]              = tgt_req_ready[lane_sel[l]][l];
        end
    end

    // ---------------- response side ----------------
    logic [NUM_TARGETS-1:0][PW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [TAG_W-1:0]                  mem_tag_q   [NUM_TARGETS][RSP_DEPTH];
    logic [TAG_W-1:0]                  mem_tag_d   [NUM_TARGETS][RSP_DEPTH];
    logic [NUM_REQS-1:0]               mem_tmask_q [NUM_TARGETS][RSP_DEPTH];
    logic [NUM_REQS-1:0]               mem_tmask_d [NUM_TARGETS][RSP_DEPTH];
    logic [NUM_REQS-1:0][DATA_W-1:0]   mem_data_q  [NUM_TARGETS][RSP_DEPTH];
    logic [NUM_REQS-1:0][DATA_W-1:0]   mem_data_d  [NUM_TARGETS][RSP_DEPTH];
    logic [NUM_TARGETS-1:0]            fifo_empty, fifo_full, push;
    logic [TW-1:0]                     rr_ptr_q, rr_ptr_d, lock_gnt_q, lock_gnt_d, gnt, gnt_rr;
    logic                              lock_q, lock_d, rsp_pop;

    // FIFO status; ready is forced low while reset is held.
    always_comb begin
        for (int t = 0; t < NUM_TARGETS; t++) begin
            fifo_empty[t]    = (wptr_q[t] == rptr_q[t]);
            fifo_full[t]     = (wptr_q[t][PW] != rptr_q[t][PW]) &&
                               (wptr_q[t][PW-1:0] == rptr_q[t][PW-1:0]);
            tgt_rsp_ready[t] = ~fifo_full[t] & ~rst_i;
            push[t]          = tgt_rsp_valid[t] & tgt_rsp_ready[t];
        end
    end

    // Round-robin pick from rr_ptr upward; a stalled grant stays locked.
    always_comb begin
        int idx;
        logic found;
        gnt_rr = rr_ptr_q;
        found  = 1'b0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_TARGETS) idx = idx - NUM_TARGETS;
            if (!found && !fifo_empty[idx]) begin
                gnt_rr = TW'(idx);
                found  = 1'b1;
            end
        end
        gnt            = lock_q ? lock_gnt_q : gnt_rr;
        pipe_rsp_valid = ~&fifo_empty;
        rsp_pop        = pipe_rsp_valid & pipe_rsp_ready;
        pipe_rsp_tag   = '0;
        pipe_rsp_tmask = '0;
        pipe_rsp_data  = '0;
        if (pipe_rsp_valid) begin
            pipe_rsp_tag   = mem_tag_q[gnt][rptr_q[gnt][PW-1:0]];
            pipe_rsp_tmask = mem_tmask_q[gnt][rptr_q[gnt][PW-1:0]];
            pipe_rsp_data  = mem_data_q[gnt][rptr_q[gnt][PW-1:0]];
        end
    end

    // Next-state for pointers, storage, arbiter pointer and lock.
    always_comb begin
        mem_tag_d   = mem_tag_q;
        mem_tmask_d = mem_tmask_q;
        mem_data_d  = mem_data_q;
        for (int t = 0; t < NUM_TARGETS; t++) begin
            wptr_d[t] = wptr_q[t] + (PW+1)'(push[t]);
            rptr_d[t] = rptr_q[t] + (PW+1)'(rsp_pop && (gnt == TW'(t)));
            if (push[t]) begin
                mem_tag_d[t][wptr_q[t][PW-1:0]]   = tgt_rsp_tag[t];
                mem_tmask_d[t][wptr_q[t][PW-1:0]] = tgt_rsp_tmask[t];
                mem_data_d[t][wptr_q[t][PW-1:0]]  = tgt_rsp_data[t];
            end
        end
        lock_d     = pipe_rsp_valid & ~pipe_rsp_ready;
        lock_gnt_d = gnt;
        rr_ptr_d   = rr_ptr_q;
        if (rsp_pop)
            rr_ptr_d = (gnt == TW'(NUM_TARGETS - 1)) ? '0 : gnt + TW'(1);
    end

    // State registers; reset empties every FIFO at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_gnt_q <= '0;
            for (int t = 0; t < NUM_TARGETS; t++) begin
                for (int d = 0; d < RSP_DEPTH; d++) begin
                    mem_tag_q[t][d]   <= '0;
                    mem_tmask_q[t][d] <= '0;
                    mem_data_q[t][d]  <= '0;
                end
            end
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            lock_gnt_q  <= lock_gnt_d;
            mem_tag_q   <= mem_tag_d;
            mem_tmask_q <= mem_tmask_d;
            mem_data_q  <= mem_data_d;
        end
    end

endmodule

// File: tb/tb_one_to_n_router.sv
// Bench for one_to_n_router: directed routing/response scenarios plus random
// traffic, all checked against a queue-based reference model.
module tb_one_to_n_router;

    localparam int NR = 4, NT = 3, AW = 30, DW = 32, TGW = 8, DEP = 2;

    logic clk = 1'b0;
    logic rst;
    logic [NR-1:0]                  pipe_req_valid, pipe_req_rw, pipe_req_ready;
    logic [NR-1:0][3:0]             pipe_req_byteen;
    logic [NR-1:0][AW-1:0]          pipe_req_addr;
    logic [NR-1:0][DW-1:0]          pipe_req_data;
    logic [NR-1:0][TGW-1:0]         pipe_req_tag;
    logic [NT-1:0][NR-1:0]          tgt_req_valid, tgt_req_rw, tgt_req_ready;
    logic [NT-1:0][NR-1:0][3:0]     tgt_req_byteen;
    logic [NT-1:0][NR-1:0][AW-1:0]  tgt_req_addr;
    logic [NT-1:0][NR-1:0][DW-1:0]  tgt_req_data;
    logic [NT-1:0][NR-1:0][TGW-1:0] tgt_req_tag;
    logic [NT-1:0]                  tgt_rsp_valid, tgt_rsp_ready;
    logic [NT-1:0][TGW-1:0]         tgt_rsp_tag;
    logic [NT-1:0][NR-1:0]          tgt_rsp_tmask;
    logic [NT-1:0][NR-1:0][DW-1:0]  tgt_rsp_data;
    logic                           pipe_rsp_valid, pipe_rsp_ready;
    logic [TGW-1:0]                 pipe_rsp_tag;
    logic [NR-1:0]                  pipe_rsp_tmask;
    logic [NR-1:0][DW-1:0]          pipe_rsp_data;

    one_to_n_router dut (
        .clk_i(clk), .rst_i(rst),
        .pipe_req_valid(pipe_req_valid), .pipe_req_rw(pipe_req_rw),
        .pipe_req_byteen(pipe_req_byteen), .pipe_req_addr(pipe_req_addr),
        .pipe_req_data(pipe_req_data), .pipe_req_tag(pipe_req_tag),
        .pipe_req_ready(pipe_req_ready),
        .tgt_req_valid(tgt_req_valid), .tgt_req_rw(tgt_req_rw),
        .tgt_req_byteen(tgt_req_byteen), .tgt_req_addr(tgt_req_addr),
        .tgt_req_data(tgt_req_data), .tgt_req_tag(tgt_req_tag),
        .tgt_req_ready(tgt_req_ready),
        .tgt_rsp_valid(tgt_rsp_valid), .tgt_rsp_tag(tgt_rsp_tag),
        .tgt_rsp_tmask(tgt_rsp_tmask), .tgt_rsp_data(tgt_rsp_data),
        .tgt_rsp_ready(tgt_rsp_ready),
        .pipe_rsp_valid(pipe_rsp_valid), .pipe_rsp_tag(pipe_rsp_tag),
        .pipe_rsp_tmask(pipe_rsp_tmask), .pipe_rsp_data(pipe_rsp_data),
        .pipe_rsp_ready(pipe_rsp_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TGW-1:0]   tag;
        logic [NR-1:0]    tmask;
        logic [NR*DW-1:0] data;
    } rsp_t;

    rsp_t q[NT][$];
    int   rr_m, lgnt_m;
    bit   lock_m;
    int   n_vec, n_err;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic int win(input logic [AW-1:0] a);
        if (a < 30'h100) return 0;
        if (a < 30'h200) return 1;
        return 2;
    endfunction

    function automatic int exp_grant();
        if (lock_m) return lgnt_m;
        for (int i = 0; i < NT; i++)
            if (q[(rr_m + i) % NT].size() > 0) return (rr_m + i) % NT;
        return -1;
    endfunction

    task automatic model_clear();
        for (int t = 0; t < NT; t++) q[t].delete();
        rr_m = 0; lock_m = 0; lgnt_m = 0;
    endtask

    // Compare request routing of the current inputs against the window map.
    task automatic check_route();
        logic [NR-1:0] ev, er, erdy;
        logic [NR-1:0][3:0] eb;
        logic [NR-1:0][AW-1:0] ea;
        logic [NR-1:0][DW-1:0] ed;
        logic [NR-1:0][TGW-1:0] etg;
        #1;
        erdy = '0;
        for (int t = 0; t < NT; t++) begin
            ev = '0; er = '0; eb = '0; ea = '0; ed = '0; etg = '0;
            for (int l = 0; l < NR; l++) begin
                if (win(pipe_req_addr[l]) == t) begin
                    ev[l] = pipe_req_valid[l]; er[l] = pipe_req_rw[l];
                    eb[l] = pipe_req_byteen[l]; ea[l] = pipe_req_addr[l];
                    ed[l] = pipe_req_data[l]; etg[l] = pipe_req_tag[l];
                    erdy[l] = tgt_req_ready[t][l];
                end
            end
            chk("rt_vld", 128'(tgt_req_valid[t]), 128'(ev));
            chk("rt_rw", 128'(tgt_req_rw[t]), 128'(er));
            chk("rt_ben", 128'(tgt_req_byteen[t]), 128'(eb));
            chk("rt_addr", 128'(tgt_req_addr[t]), 128'(ea));
            chk("rt_data", 128'(tgt_req_data[t]), 128'(ed));
            chk("rt_tag", 128'(tgt_req_tag[t]), 128'(etg));
        end
        chk("rt_rdy", 128'(pipe_req_ready), 128'(erdy));
    endtask

    task automatic check_rsp();
        int g;
        g = exp_grant();
        chk("rsp_vld", 128'(pipe_rsp_valid), 128'(g >= 0));
        if (g >= 0) begin
            chk("rsp_tag", 128'(pipe_rsp_tag), 128'(q[g][0].tag));
            chk("rsp_tmask", 128'(pipe_rsp_tmask), 128'(q[g][0].tmask));
            chk("rsp_data", 128'(pipe_rsp_data), 128'(q[g][0].data));
        end else begin
            chk("rsp_zero", 128'({pipe_rsp_tag, pipe_rsp_tmask, pipe_rsp_data}), 128'(0));
        end
        for (int t = 0; t < NT; t++)
            chk("trdy", 128'(tgt_rsp_ready[t]), 128'(q[t].size() < DEP));
    endtask

    // Apply one clock of the spec's response rules to the model.
    task automatic model_clk();
        int g;
        bit acc[NT];
        g = exp_grant();
        for (int t = 0; t < NT; t++) acc[t] = tgt_rsp_valid[t] && (q[t].size() < DEP);
        if (g >= 0 && pipe_rsp_ready) begin
            void'(q[g].pop_front());
            rr_m = (g + 1) % NT;
        end
        lock_m = (g >= 0) && !pipe_rsp_ready;
        lgnt_m = g;
        for (int t = 0; t < NT; t++)
            if (acc[t]) q[t].push_back('{tgt_rsp_tag[t], tgt_rsp_tmask[t], tgt_rsp_data[t]});
    endtask

    // Entered and left at a negedge with inputs already driven.
    task automatic cycle();
        #1 check_rsp();
        @(posedge clk);
        model_clk();
        @(negedge clk);
    endtask

    task automatic set_rsp(input int t, input logic [TGW-1:0] tg);
        tgt_rsp_tag[t]   = tg;
        tgt_rsp_tmask[t] = NR'($urandom);
        tgt_rsp_data[t]  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic rand_req();
        for (int l = 0; l < NR; l++) begin
            pipe_req_addr[l]   = AW'($urandom_range(0, 'h3FF));
            pipe_req_data[l]   = $urandom;
            pipe_req_tag[l]    = TGW'($urandom);
            pipe_req_byteen[l] = 4'($urandom);
        end
        pipe_req_valid = NR'($urandom);
        pipe_req_rw    = NR'($urandom);
        tgt_req_ready  = (NT*NR)'($urandom);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        model_clear();
        rst = 1'b1;
        pipe_req_valid = '0; pipe_req_rw = '0; pipe_req_byteen = '0;
        pipe_req_addr = '0; pipe_req_data = '0; pipe_req_tag = '0;
        tgt_req_ready = '0; tgt_rsp_valid = '0; tgt_rsp_tag = '0;
        tgt_rsp_tmask = '0; tgt_rsp_data = '0; pipe_rsp_ready = 1'b0;

        // reset state
        @(negedge clk); @(negedge clk);
        chk("rst_vld", 128'(pipe_rsp_valid), 128'(0));
        chk("rst_trdy", 128'(tgt_rsp_ready), 128'(0));
        rst = 1'b0;
        #1 chk("rel_trdy", 128'(tgt_rsp_ready), 128'(3'b111));
        @(negedge clk);

        // directed routing: lanes 0,3 -> T0, lane 1 -> T1, lane 2 -> T2
        pipe_req_valid = 4'hF;
        pipe_req_addr[0] = 30'h010; pipe_req_addr[1] = 30'h150;
        pipe_req_addr[2] = 30'h300; pipe_req_addr[3] = 30'h0FF;
        tgt_req_ready[0] = 4'b0001; tgt_req_ready[1] = 4'b0010; tgt_req_ready[2] = 4'b0000;
        #1;
        chk("rt_t0", 128'(tgt_req_valid[0]), 128'(4'b1001));
        chk("rt_t1", 128'(tgt_req_valid[1]), 128'(4'b0010));
        chk("rt_t2", 128'(tgt_req_valid[2]), 128'(4'b0100));
        chk("rt_prdy", 128'(pipe_req_ready), 128'(4'b0011));
        tgt_req_ready[2] = 4'b0100;
        #1 chk("rt_prdy2", 128'(pipe_req_ready), 128'(4'b0111));
        // window boundaries
        pipe_req_addr[0] = 30'h0FF; pipe_req_addr[1] = 30'h100;
        pipe_req_addr[2] = 30'h200; pipe_req_addr[3] = 30'h1FF;
        #1;
        chk("bnd_t0", 128'(tgt_req_valid[0]), 128'(4'b0001));
        chk("bnd_t1", 128'(tgt_req_valid[1]), 128'(4'b1010));
        chk("bnd_t2", 128'(tgt_req_valid[2]), 128'(4'b0100));
        for (int i = 0; i < 40; i++) begin
            rand_req();
            check_route();
        end
        @(negedge clk);

        // three targets push together, drained in RR order
        tgt_rsp_valid = 3'b111; pipe_rsp_ready = 1'b1;
        set_rsp(0, 8'hA0); set_rsp(1, 8'hB0); set_rsp(2, 8'hC0);
        cycle();
        tgt_rsp_valid = '0;
        chk("ord0", 128'(pipe_rsp_tag), 128'(8'hA0));
        cycle(); chk("ord1", 128'(pipe_rsp_tag), 128'(8'hB0));
        cycle(); chk("ord2", 128'(pipe_rsp_tag), 128'(8'hC0));
        cycle(); chk("ord_empty", 128'(pipe_rsp_valid), 128'(0));

        // stalled output holds A1 while T1 pushes B1
        pipe_rsp_ready = 1'b0; tgt_rsp_valid = 3'b001; set_rsp(0, 8'hA1);
        cycle();
        tgt_rsp_valid = 3'b010; set_rsp(1, 8'hB1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            tgt_rsp_valid = '0;
            chk("hold", 128'(pipe_rsp_tag), 128'(8'hA1));
        end
        pipe_rsp_ready = 1'b1;
        cycle(); chk("after_hold", 128'(pipe_rsp_tag), 128'(8'hB1));
        cycle();  // rr now points at T2

        // lock beats RR: T2 arrives while T0 is stalled on the output
        pipe_rsp_ready = 1'b0; tgt_rsp_valid = 3'b001; set_rsp(0, 8'hA2);
        cycle();
        tgt_rsp_valid = 3'b100; set_rsp(2, 8'hC2);
        cycle(); tgt_rsp_valid = '0;
        chk("lock", 128'(pipe_rsp_tag), 128'(8'hA2));
        pipe_rsp_ready = 1'b1;
        cycle(); chk("lock_next", 128'(pipe_rsp_tag), 128'(8'hC2));
        cycle();

        // full FIFO: third push waits for a pop, no push into full on pop
        pipe_rsp_ready = 1'b0; tgt_rsp_valid = 3'b001;
        set_rsp(0, 8'hD0); cycle();
        set_rsp(0, 8'hD1); cycle();
        chk("full", 128'(tgt_rsp_ready[0]), 128'(0));
        set_rsp(0, 8'hD2); cycle();
        chk("full_hold", 128'(tgt_rsp_ready[0]), 128'(0));
        pipe_rsp_ready = 1'b1; cycle();
        chk("pop_frees", 128'(tgt_rsp_ready[0]), 128'(1));
        chk("pop_head", 128'(pipe_rsp_tag), 128'(8'hD1));
        pipe_rsp_ready = 1'b0; cycle();
        tgt_rsp_valid = '0;
        chk("third_in", 128'(tgt_rsp_ready[0]), 128'(0));
        pipe_rsp_ready = 1'b1;
        cycle(); chk("third_out", 128'(pipe_rsp_tag), 128'(8'hD2));
        cycle();

        // async reset discards buffered data and rr pointer
        pipe_rsp_ready = 1'b0; tgt_rsp_valid = 3'b110;
        set_rsp(1, 8'hB3); set_rsp(2, 8'hC3);
        cycle();
        tgt_rsp_valid = '0;
        #2 rst = 1'b1;
        #1;
        chk("arst_vld", 128'(pipe_rsp_valid), 128'(0));
        chk("arst_trdy", 128'(tgt_rsp_ready), 128'(0));
        model_clear();
        @(negedge clk); rst = 1'b0;
        tgt_rsp_valid = 3'b111;
        set_rsp(0, 8'hA4); set_rsp(1, 8'hB4); set_rsp(2, 8'hC4);
        cycle(); tgt_rsp_valid = '0;
        chk("rst_first", 128'(pipe_rsp_tag), 128'(8'hA4));
        pipe_rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // random traffic on both paths
        for (int i = 0; i < 400; i++) begin
            rand_req();
            tgt_rsp_valid = NT'($urandom);
            for (int t = 0; t < NT; t++) set_rsp(t, TGW'($urandom));
            pipe_rsp_ready = ($urandom_range(0, 2) != 0);
            if (i % 10 == 0) check_route();
            cycle();
        end
        tgt_rsp_valid = '0; pipe_rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        chk("drained", 128'(pipe_rsp_valid), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
